// File: rtl/mult32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mult32_seq (with helper adder32)
//  Purpose  : Sequential 32x32 -> 64-bit shift-add multiplier supporting
//             unsigned (MULTU) and two's-complement (MULT) operands.
//             Operands are reduced to magnitudes on start, multiplied over
//             32 single-bit iterations through one 32-bit adder, and the
//             product is negated at the end when the result sign is negative.
//  Ports    : clk        - rising-edge clock
//             rst_n      - synchronous active-low reset
//             start      - request pulse; A/B/is_signed sampled on same edge
//             is_signed  - 1 = signed multiply, 0 = unsigned multiply
//             A, B       - multiplicand / multiplier
//             busy       - high while an operation is in progress
//             done       - one-cycle pulse when hi/lo carry a new result
//             hi, lo     - upper / lower 32 bits of the 64-bit product
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  adder32 : plain 32-bit ripple/carry adder with carry-out flag
// ----------------------------------------------------------------------------
module adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        flgCarry
);

    assign {flgCarry, S} = {1'b0, A} + {1'b0, B} + {32'b0, Cin};

endmodule

// ----------------------------------------------------------------------------
//  mult32_seq : top level
// ----------------------------------------------------------------------------
module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Last iteration index: the iteration phase runs counter values 0..31.
    localparam logic [4:0] c_ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;     // multiplicand magnitude
    logic [WIDTH-1:0]   r_mplier;    // multiplier magnitude, consumed LSB first
    logic               r_sign;      // result must be negated in FIN
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [4:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_sign;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_result;

    // Magnitudes are taken as unsigned values, so -2^31 becomes 0x80000000
    // (= 2^31) without any overflow concern.
    assign w_a_mag = (is_signed && A[WIDTH-1]) ? (~A + 32'd1) : A;
    assign w_b_mag = (is_signed && B[WIDTH-1]) ? (~B + 32'd1) : B;

    // A zero operand forces a positive sign so there is no negative-zero path.
    assign w_sign  = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]) & (|A) & (|B);

    // Adding zero when the multiplier bit is clear also yields carry = 0, so
    // the shifted-in MSB is correct in both cases.
    assign w_add_b = r_mplier[0] ? r_mcand : '0;

    adder32 u_adder (
        .A        (r_acc_hi),
        .B        (w_add_b),
        .Cin      (1'b0),
        .S        (w_sum),
        .flgCarry (w_carry)
    );

    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_result = r_sign ? (~w_prod + 64'd1) : w_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_sign   <= w_sign;
                        r_acc_hi <= '0;
                        r_acc_lo <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    // {carry, sum, acc_lo} shifted right by one position.
                    r_acc_hi <= {w_carry, w_sum[WIDTH-1:1]};
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == c_ITER_LAST) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_hi    <= w_result[2*WIDTH-1:WIDTH];
                    r_lo    <= w_result[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/mult32_seq.md
MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; operands are sampled on the same edge.
REQ-005 is_signed  input  1  1 = two's-complement multiply (MULT); 0 = unsigned (MULTU).
REQ-006 A  input  32  multiplicand.
REQ-007 B  input  32  multiplier.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; hi/lo valid.
REQ-010 hi  output  32  upper 32 bits of the 64-bit product.
REQ-011 lo  output  32  lower 32 bits of the 64-bit product.

Function
REQ-012 Block SHALL be a shift-add multiplier whose 32-bit partial-sum additions go through one internal adder32 instance (Cin tied 0); adder32 flgCarry supplies the bit shifted into the accumulator MSB.
REQ-013 FSM states SHALL be IDLE, ITER, FIN.
REQ-014 IDLE: start=1 on an edge SHALL latch |A| and |B| (magnitudes if is_signed=1, raw values otherwise), latch the result sign (A[31]^B[31])&is_signed, clear the accumulator, load iteration counter = 0, go to ITER.
REQ-015 ITER: each cycle, if multiplier LSB = 1, accumulator_hi SHALL become accumulator_hi + multiplicand; then {carry, acc_hi, acc_lo} SHALL shift right by 1; counter SHALL increment.
REQ-016 ITER SHALL last exactly 32 cycles (counter 0..31); on counter = 31, next state SHALL be FIN.
REQ-017 FIN: if latched sign = 1, the 64-bit result SHALL be two's-complement negated; hi/lo SHALL be registered; done SHALL pulse for one cycle; next state SHALL be IDLE.
REQ-018 Latency: done SHALL be high during the 34th cycle after the edge that sampled start; a back-to-back start is accepted in the cycle done is high (state is IDLE) at the earliest.
REQ-019 busy SHALL be 1 in ITER and FIN and 0 in IDLE; done SHALL never coincide with busy = 0 except in the FIN to IDLE handoff cycle defined by REQ-017.
REQ-020 start while busy = 1 SHALL be ignored; latched operands SHALL be unaffected.
REQ-021 hi/lo SHALL hold the last result until the next FIN; they SHALL NOT change during ITER.
REQ-022 Magnitude of 0x80000000 SHALL be handled as unsigned 2^31 (no overflow); the 64-bit product SHALL be exact for all input pairs.
REQ-023 A or B = 0 SHALL still take the full 34-cycle latency; result 0 with sign forced to 0 (no negative zero path).

Reset
REQ-024 rst_n = 0 at a rising edge SHALL force state IDLE, busy = 0, done = 0, hi = 0, lo = 0, counter = 0, accumulator = 0.
REQ-025 Reset mid-operation SHALL abort without a done pulse; start in the first cycle after rst_n returns high SHALL be accepted.
REQ-026 start asserted together with rst_n = 0 SHALL be ignored.

Verification
REQ-027 Unsigned 6 x 7, is_signed = 0 -> done after 34 cycles, hi = 0x00000000, lo = 0x0000002A.
REQ-028 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-029 Signed -2 x 3 (0xFFFFFFFE, 0x00000003) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; signed -1 x -1 -> hi = 0, lo = 1.
REQ-030 Signed 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-031 start with A = 5, B = 5; re-pulse start at cycle 10 with A = 9, B = 9 -> single done, lo = 25; hi/lo unchanged until then.
REQ-032 start with A = 3, B = 4; rst_n = 0 at cycle 15 -> busy = 0, hi/lo = 0, no done; a fresh 3 x 4 afterwards -> lo = 12 at 34 cycles.
